seq_instrucao: RTL and testbench

Instruction sequencer for the X/Y/Z register + ULA datapath. It accepts one opcode at a time through a valid/ready handshake and walks a fixed micro-sequence of register control codes (tx, ty, tz) and ULA function codes (tula), one step per clock. It signals completion with a one-cycle `done` pulse. It replaces the free-running control loop with an on-demand, per-instruction controller sitting between the instruction source and the datapath.

---
 rtl/seq_pkg.sv | 37 +++
 rtl/seq_decode.sv | 38 +++
 rtl/seq_instrucao.sv | 133 +++++++++++++
 tb/tb_seq_instrucao.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer: register control codes,
// ULA function codes, opcodes and FSM state constants.
package seq_pkg;

  // Register control codes (tx/ty/tz)
  localparam logic [1:0] REG_CLEAR  = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_HOLD   = 2'd2;
  localparam logic [1:0] REG_SHIFTR = 2'd3;

  // ULA function codes
  localparam logic [2:0] ULA_ADD   = 3'd0;
  localparam logic [2:0] ULA_SUB   = 3'd1;
  localparam logic [2:0] ULA_AND   = 3'd2;
  localparam logic [2:0] ULA_OR    = 3'd3;
  localparam logic [2:0] ULA_PASSY = 3'd4;

  // Opcodes; 6..15 are undefined
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;

  // FSM states (ST_TRAP is only reachable with SEQ_TRAP_EN)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LDX  = 3'd1;
  localparam state_t ST_LDY  = 3'd2;
  localparam state_t ST_SHY  = 3'd3;
  localparam state_t ST_EXEC = 3'd4;
  localparam state_t ST_WRZ  = 3'd5;
  localparam state_t ST_FIN  = 3'd6;
  localparam state_t ST_TRAP = 3'd7;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: legality, first micro-step and ULA code.
// Build option: SEQ_TRAP_EN routes undefined opcodes to ST_TRAP instead of ST_FIN.
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal,
  output state_t     first_state,
  output logic [2:0] ula_code
);

  // Opcode -> {legal, first_state, ula_code}; SHR uses PASSY for its write-back
  always_comb begin
    legal       = 1'b1;
    first_state = ST_LDX;
    ula_code    = ULA_ADD;
    case (opcode)
      OP_NOP: first_state = ST_FIN;
      OP_ADD: ula_code    = ULA_ADD;
      OP_SUB: ula_code    = ULA_SUB;
      OP_SHR: begin
        first_state = ST_LDY;
        ula_code    = ULA_PASSY;
      end
      OP_AND: ula_code    = ULA_AND;
      OP_OR:  ula_code    = ULA_OR;
      default: begin
        legal = 1'b0;
`ifdef SEQ_TRAP_EN
        first_state = ST_TRAP;
`else
        first_state = ST_FIN;
`endif
      end
    endcase
  end

endmodule

// File: rtl/seq_instrucao.sv
// Per-instruction sequencer for the X/Y/Z register + ULA datapath.
// Accepts one opcode per valid/ready handshake and steps through its
// micro-sequence one state per clock, pulsing done in FIN.
// Build option: SEQ_TRAP_EN adds a TRAP state and the trap_clr input.
//
// Handshake: an opcode is taken on a rising edge where instr_valid and
// instr_ready are both high; instr_ready is a pure decode of state (IDLE or
// FIN), so the source may hold instr_valid while ready is low and the
// opcode is captured exactly once.
module seq_instrucao
  import seq_pkg::*;
#(
  parameter int W_CODE = 4
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef SEQ_TRAP_EN
  input  logic              trap_clr,
`endif
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  output logic [W_CODE-1:0] tx,
  output logic [W_CODE-1:0] ty,
  output logic [W_CODE-1:0] tz,
  output logic [W_CODE-1:0] tula,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output state_t            state_dbg
);

  state_t     st, st_n;
  logic [2:0] ula_q, ula_n;
  logic       ill_q, ill_n;
  logic       accept;

  logic       dec_legal;
  state_t     dec_first;
  logic [2:0] dec_ula;

  logic [1:0] tx_n, ty_n, tz_n;
  logic [2:0] tula_n;
  logic       busy_n, done_n, illegal_n;

  seq_decode u_decode (
    .opcode      (opcode),
    .legal       (dec_legal),
    .first_state (dec_first),
    .ula_code    (dec_ula)
  );

  assign instr_ready = (st == ST_IDLE) || (st == ST_FIN);
  assign accept      = instr_valid && instr_ready;
  assign state_dbg   = st;

  // Next state, plus the instruction attributes as they will be after this edge
  always_comb begin
    st_n  = st;
    ula_n = accept ? dec_ula : ula_q;
    ill_n = accept ? !dec_legal : ill_q;
    case (st)
      ST_IDLE: if (accept) st_n = dec_first;
      ST_LDX:  st_n = ST_LDY;
      ST_LDY:  st_n = (ula_q == ULA_PASSY) ? ST_SHY : ST_EXEC;
      ST_SHY:  st_n = ST_WRZ;
      ST_EXEC: st_n = ST_WRZ;
      ST_WRZ:  st_n = ST_FIN;
      ST_FIN:  st_n = accept ? dec_first : ST_IDLE;
`ifdef SEQ_TRAP_EN
      ST_TRAP: st_n = trap_clr ? ST_FIN : ST_TRAP;
`endif
      default: st_n = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so outputs come straight from flops
  always_comb begin
    tx_n   = REG_HOLD;
    ty_n   = REG_HOLD;
    tz_n   = REG_HOLD;
    tula_n = ULA_ADD;
    case (st_n)
      ST_LDX:  tx_n = REG_LOAD;
      ST_LDY:  ty_n = REG_LOAD;
      ST_SHY:  ty_n = REG_SHIFTR;
      ST_EXEC: tula_n = ula_n;
      ST_WRZ: begin
        tz_n   = REG_LOAD;
        tula_n = ula_n;
      end
      default: ;
    endcase
    busy_n    = (st_n != ST_IDLE);
    done_n    = (st_n == ST_FIN);
    illegal_n = ((st_n == ST_FIN) && ill_n) || (st_n == ST_TRAP);
  end

  // State register and latched instruction attributes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st    <= ST_IDLE;
      ula_q <= ULA_ADD;
      ill_q <= 1'b0;
    end else begin
      st    <= st_n;
      ula_q <= ula_n;
      ill_q <= ill_n;
    end
  end

  // Registered control outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx      <= W_CODE'(REG_HOLD);
      ty      <= W_CODE'(REG_HOLD);
      tz      <= W_CODE'(REG_HOLD);
      tula    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      tx      <= W_CODE'(tx_n);
      ty      <= W_CODE'(ty_n);
      tz      <= W_CODE'(tz_n);
      tula    <= W_CODE'(tula_n);
      busy    <= busy_n;
      done    <= done_n;
      illegal <= illegal_n;
    end
  end

endmodule

// File: tb/tb_seq_instrucao.sv
// Directed bench for seq_instrucao. Each cycle's expected output vector
// {tx,ty,tz,tula,busy,done,illegal,instr_ready} is pushed into exp_q and
// compared at the falling edge of that cycle.
module tb_seq_instrucao;

  logic       clock;
  logic       reset_n;
  logic       trap_clr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic [3:0] tx, ty, tz, tula;
  logic       busy, done, illegal;
  logic [2:0] state_dbg;

  logic [19:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  seq_instrucao #(.W_CODE(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
`ifdef SEQ_TRAP_EN
    .trap_clr    (trap_clr),
`endif
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .tx          (tx),
    .ty          (ty),
    .tz          (tz),
    .tula        (tula),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] ev(int t_x, int t_y, int t_z, int t_u,
                                     int b, int d, int il, int r);
    return {4'(t_x), 4'(t_y), 4'(t_z), 4'(t_u), 1'(b), 1'(d), 1'(il), 1'(r)};
  endfunction

  function automatic logic [19:0] obs();
    return {tx, ty, tz, tula, busy, done, illegal, instr_ready};
  endfunction

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, then drive next inputs
  task automatic cyc(input string tag, input logic v, input logic [3:0] op, input logic clr);
    logic [19:0] e;
    @(negedge clock);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs(), e);
    end
    instr_valid = v;
    opcode      = v ? op : 4'($urandom_range(15, 0));
    trap_clr    = clr;
  endtask

  function automatic logic [19:0] x_idle();
    return ev(2, 2, 2, 0, 0, 0, 0, 1);
  endfunction

  function automatic logic [19:0] x_fin(int il);
    return ev(2, 2, 2, 0, 1, 1, il, 1);
  endfunction

  task automatic push_arith(input int u);
    exp_q.push_back(ev(1, 2, 2, 0, 1, 0, 0, 0));  // LDX
    exp_q.push_back(ev(2, 1, 2, 0, 1, 0, 0, 0));  // LDY
    exp_q.push_back(ev(2, 2, 2, u, 1, 0, 0, 0));  // EXEC
    exp_q.push_back(ev(2, 2, 1, u, 1, 0, 0, 0));  // WRZ
  endtask

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    opcode      = 4'd0;
    trap_clr    = 1'b0;
    repeat (2) @(negedge clock);
    check("reset", obs(), x_idle());
    reset_n = 1'b1;

    // ADD: 5 cycles to done
    exp_q.push_back(x_idle());
    push_arith(0);
    exp_q.push_back(x_fin(0));
    exp_q.push_back(x_idle());
    cyc("add_idle", 1'b1, 4'd1, 1'b0);
    repeat (6) cyc("add", 1'b0, 4'd0, 1'b0);

    // SHR: LDY, SHY, WRZ(PASSY), FIN
    exp_q.push_back(x_idle());
    exp_q.push_back(ev(2, 1, 2, 0, 1, 0, 0, 0));
    exp_q.push_back(ev(2, 3, 2, 0, 1, 0, 0, 0));
    exp_q.push_back(ev(2, 2, 1, 4, 1, 0, 0, 0));
    exp_q.push_back(x_fin(0));
    exp_q.push_back(x_idle());
    cyc("shr_idle", 1'b1, 4'd3, 1'b0);
    repeat (5) cyc("shr", 1'b0, 4'd0, 1'b0);

    // SUB then OR held on the bus, accepted in FIN with no bubble
    exp_q.push_back(x_idle());
    push_arith(1);
    exp_q.push_back(x_fin(0));
    push_arith(3);
    exp_q.push_back(x_fin(0));
    exp_q.push_back(x_idle());
    cyc("b2b_idle", 1'b1, 4'd2, 1'b0);
    repeat (5) cyc("b2b_sub", 1'b1, 4'd5, 1'b0);
    repeat (5) cyc("b2b_or", 1'b0, 4'd0, 1'b0);
    cyc("b2b_end", 1'b0, 4'd0, 1'b0);

    // NOP: 1 cycle to done
    exp_q.push_back(x_idle());
    exp_q.push_back(x_fin(0));
    exp_q.push_back(x_idle());
    cyc("nop_idle", 1'b1, 4'd0, 1'b0);
    repeat (2) cyc("nop", 1'b0, 4'd0, 1'b0);

    // Illegal opcode 9
`ifdef SEQ_TRAP_EN
    exp_q.push_back(x_idle());
    repeat (3) exp_q.push_back(ev(2, 2, 2, 0, 1, 0, 1, 0));  // TRAP
    exp_q.push_back(x_fin(1));
    exp_q.push_back(x_idle());
    cyc("ill_idle", 1'b1, 4'd9, 1'b0);
    repeat (2) cyc("ill_trap", 1'b0, 4'd0, 1'b0);
    cyc("ill_trap", 1'b0, 4'd0, 1'b1);
    cyc("ill_fin", 1'b0, 4'd0, 1'b0);
    cyc("ill_end", 1'b0, 4'd0, 1'b0);
`else
    exp_q.push_back(x_idle());
    exp_q.push_back(x_fin(1));
    exp_q.push_back(x_idle());
    cyc("ill_idle", 1'b1, 4'd9, 1'b0);
    repeat (2) cyc("ill", 1'b0, 4'd0, 1'b0);
`endif

    // Reset during EXEC of ADD, then a full ADD
    exp_q.push_back(x_idle());
    exp_q.push_back(ev(1, 2, 2, 0, 1, 0, 0, 0));
    exp_q.push_back(ev(2, 1, 2, 0, 1, 0, 0, 0));
    exp_q.push_back(ev(2, 2, 2, 0, 1, 0, 0, 0));
    cyc("mid_idle", 1'b1, 4'd1, 1'b0);
    repeat (3) cyc("mid", 1'b0, 4'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_now", obs(), x_idle());
    @(negedge clock);
    check("mid_rst_hold", obs(), x_idle());
    reset_n = 1'b1;
    exp_q.push_back(x_idle());
    push_arith(0);
    exp_q.push_back(x_fin(0));
    exp_q.push_back(x_idle());
    cyc("readd_idle", 1'b1, 4'd1, 1'b0);
    repeat (6) cyc("readd", 1'b0, 4'd0, 1'b0);

    check("q_empty", 20'(exp_q.size()), 20'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
